// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the ula command sequencer.
//   op_t    : command opcodes as carried on cmd_op
//   state_t : sequencer states
//   FLG_*   : bit positions inside rsp_flags ({C, N, Z})
//   MUL_STEPS : shift-add iterations for an 8x8 multiply
package ula_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MUL_IT = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam int unsigned FLG_Z     = 0;
    localparam int unsigned FLG_N     = 1;
    localparam int unsigned FLG_C     = 2;
    localparam int unsigned MUL_STEPS = 8;

endpackage

// File: rtl/ula.sv
// ula: 8-bit combinational add/sub unit.
//   A, B : operands
//   op   : 0 = A + B, 1 = A - B
//   S    : 8-bit result (carry/borrow not exported; derived by the caller)
module ula (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       op,
    output logic [7:0] S
);

    assign S = op ? (A - B) : (A + B);

endmodule

// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: command sequencer around a single ula instance.
// Accepts ADD/SUB/CMP (single cycle) and MUL (8-step shift-add) commands
// and returns a 16-bit result with {C, N, Z} flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b : opcode and operands, captured on accept
//   rsp_valid/rsp_ready  : response handshake, response held until accepted
//   rsp_data, rsp_flags  : result and {C, N, Z}
//   rsp_err              : MUL issued with MUL_EN = 0
module ula_seq_ctrl
    import ula_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err
);

    state_t     state_q, state_d;
    op_t        op_q;
    logic [7:0] a_q, b_q;
    logic [7:0] hi_q, lo_q;
    logic [2:0] cnt_q;
    logic       err_q;

    logic       accept;
    logic [7:0] ula_a, ula_b, ula_s;
    logic       ula_op;
    logic [7:0] step_sum;
    logic       step_c;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((op_t'(cmd_op) == OP_MUL) && MUL_EN)
                        state_d = MUL_IT;
                    else
                        state_d = RESP;
                end
            end
            MUL_IT: if (cnt_q == 3'(MUL_STEPS - 1)) state_d = RESP;
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ula sees hi/multiplicand while iterating, otherwise the captured
    // operands; op is only asserted while a SUB/CMP result is presented.
    always_comb begin
        ula_a  = a_q;
        ula_b  = b_q;
        ula_op = 1'b0;
        if (state_q == MUL_IT) begin
            ula_a = hi_q;
            ula_b = a_q;
        end else if ((state_q == RESP) && ((op_q == OP_SUB) || (op_q == OP_CMP))) begin
            ula_op = 1'b1;
        end
    end

    ula u_ula (
        .A  (ula_a),
        .B  (ula_b),
        .op (ula_op),
        .S  (ula_s)
    );

    // One shift-add step: the 9-bit {c, sum} is shifted right through lo.
    assign step_sum = lo_q[0] ? ula_s : hi_q;
    assign step_c   = lo_q[0] && (ula_s < hi_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                hi_q  <= '0;
                lo_q  <= cmd_b;
                cnt_q <= '0;
                err_q <= (op_t'(cmd_op) == OP_MUL) && !MUL_EN;
            end else if (state_q == MUL_IT) begin
                hi_q  <= {step_c, step_sum[7:1]};
                lo_q  <= {step_sum[0], lo_q[7:1]};
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Response is a function of held registers only, so it is stable
    // for as long as RESP is held by backpressure.
    always_comb begin
        rsp_valid = (state_q == RESP);
        rsp_data  = '0;
        rsp_flags = '0;
        rsp_err   = 1'b0;
        if (state_q == RESP) begin
            if (err_q) begin
                rsp_err = 1'b1;
            end else if (op_q == OP_MUL) begin
                rsp_data         = {hi_q, lo_q};
                rsp_flags[FLG_Z] = ({hi_q, lo_q} == 16'h0000);
                rsp_flags[FLG_N] = hi_q[7];
                rsp_flags[FLG_C] = (hi_q != 8'h00);
            end else begin
                rsp_flags[FLG_Z] = (ula_s == 8'h00);
                rsp_flags[FLG_N] = ula_s[7];
                if (op_q == OP_ADD) begin
                    rsp_data         = {8'h00, ula_s};
                    rsp_flags[FLG_C] = (ula_s < a_q);
                end else begin
                    if (op_q == OP_SUB) rsp_data = {8'h00, ula_s};
                    rsp_flags[FLG_C] = (a_q < b_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
module tb_ula_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // dut1: MUL_EN = 1
    logic        cv1, cr1, rv1, rr1, err1;
    logic [1:0]  op1;
    logic [7:0]  a1, b1;
    logic [15:0] data1;
    logic [2:0]  fl1;

    // dut0: MUL_EN = 0
    logic        cv0, cr0, rv0, rr0, err0;
    logic [1:0]  op0;
    logic [7:0]  a0, b0;
    logic [15:0] data0;
    logic [2:0]  fl0;

    int checks = 0;
    int errors = 0;

    ula_seq_ctrl #(.MUL_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv1), .cmd_ready(cr1), .cmd_op(op1), .cmd_a(a1), .cmd_b(b1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(data1), .rsp_flags(fl1), .rsp_err(err1)
    );

    ula_seq_ctrl #(.MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv0), .cmd_ready(cr0), .cmd_op(op0), .cmd_a(a0), .cmd_b(b0),
        .rsp_valid(rv0), .rsp_ready(rr0), .rsp_data(data0), .rsp_flags(fl0), .rsp_err(err0)
    );

    task automatic drive(input bit sel, input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        if (sel) begin cv1 = v; op1 = op; a1 = a; b1 = b; end
        else     begin cv0 = v; op0 = op; a0 = a; b0 = b; end
    endtask

    // Issues one command and waits (bounded) for rsp_valid. Returns the
    // number of cycles from the accepting edge to rsp_valid, or -1.
    // Leaves the bench at a falling edge with the response still pending.
    task automatic issue(input bit sel, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, output int lat);
        bit acc;
        int n;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (sel ? cr1 : cr0) begin acc = 1; break; end
            @(negedge clk);
        end
        lat = -1;
        if (!acc) begin drive(sel, 1'b0, 2'b00, 8'h00, 8'h00); return; end
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 2'b00, 8'h00, 8'h00);
        n = 1;
        while (!(sel ? rv1 : rv0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sel ? rv1 : rv0) lat = n;
    endtask

    task automatic pop(input bit sel);
        if (sel) rr1 = 1'b1; else rr0 = 1'b1;
        @(negedge clk);
        rr1 = 1'b0;
        rr0 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (rv1 !== 1'b0)      begin errors++; $display("FAIL reset_rv got %b exp 0", rv1); end
        checks++; if (data1 !== 16'h0)   begin errors++; $display("FAIL reset_data got %h exp 0000", data1); end
        checks++; if (fl1 !== 3'b000)    begin errors++; $display("FAIL reset_flags got %b exp 000", fl1); end
        checks++; if (err1 !== 1'b0)     begin errors++; $display("FAIL reset_err got %b exp 0", err1); end
        checks++; if (cr1 !== 1'b1)      begin errors++; $display("FAIL reset_ready got %b exp 1", cr1); end
        checks++; if (cr0 !== 1'b1 || rv0 !== 1'b0) begin errors++; $display("FAIL reset_dut0 got rdy=%b rv=%b exp 1 0", cr0, rv0); end
    endtask

    task automatic test_add;
        int lat;
        issue(1, 2'b00, 8'h7F, 8'h01, lat);
        checks++; if (lat !== 1)          begin errors++; $display("FAIL add_lat got %0d exp 1", lat); end
        checks++; if (data1 !== 16'h0080) begin errors++; $display("FAIL add_data got %h exp 0080", data1); end
        checks++; if (fl1 !== 3'b010)     begin errors++; $display("FAIL add_flags got %b exp 010", fl1); end
        checks++; if (cr1 !== 1'b0)       begin errors++; $display("FAIL add_busy_ready got %b exp 0", cr1); end
        pop(1);
        checks++; if (cr1 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL add_release got rdy=%b rv=%b exp 1 0", cr1, rv1); end
        issue(1, 2'b00, 8'hFF, 8'h02, lat);
        checks++; if (data1 !== 16'h0001 || fl1 !== 3'b100) begin errors++; $display("FAIL add_carry got %h/%b exp 0001/100", data1, fl1); end
        pop(1);
    endtask

    task automatic test_sub_cmp;
        int lat;
        issue(1, 2'b01, 8'h05, 8'h07, lat);
        checks++; if (lat !== 1)          begin errors++; $display("FAIL sub_lat got %0d exp 1", lat); end
        checks++; if (data1 !== 16'h00FE) begin errors++; $display("FAIL sub_data got %h exp 00fe", data1); end
        checks++; if (fl1 !== 3'b110)     begin errors++; $display("FAIL sub_flags got %b exp 110", fl1); end
        pop(1);
        issue(1, 2'b11, 8'h33, 8'h33, lat);
        checks++; if (data1 !== 16'h0000) begin errors++; $display("FAIL cmp_data got %h exp 0000", data1); end
        checks++; if (fl1 !== 3'b001)     begin errors++; $display("FAIL cmp_flags got %b exp 001", fl1); end
        pop(1);
    endtask

    task automatic test_mul;
        int lat;
        issue(1, 2'b10, 8'hFF, 8'hFF, lat);
        checks++; if (lat !== 9)          begin errors++; $display("FAIL mul_lat got %0d exp 9", lat); end
        checks++; if (data1 !== 16'hFE01) begin errors++; $display("FAIL mul_ff_data got %h exp fe01", data1); end
        checks++; if (fl1 !== 3'b110)     begin errors++; $display("FAIL mul_ff_flags got %b exp 110", fl1); end
        pop(1);
        issue(1, 2'b10, 8'h00, 8'h5A, lat);
        checks++; if (data1 !== 16'h0000 || fl1 !== 3'b001) begin errors++; $display("FAIL mul_zero got %h/%b exp 0000/001", data1, fl1); end
        pop(1);
    endtask

    task automatic test_backpressure;
        int lat;
        issue(1, 2'b10, 8'h0C, 8'h0A, lat);
        checks++; if (lat !== 9 || data1 !== 16'h0078 || fl1 !== 3'b000) begin
            errors++; $display("FAIL bp_result got lat=%0d %h/%b exp 9 0078/000", lat, data1, fl1);
        end
        drive(1, 1'b1, 2'b00, 8'h11, 8'h22);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rv1 !== 1'b1 || data1 !== 16'h0078 || fl1 !== 3'b000 || cr1 !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got rv=%b %h/%b rdy=%b exp 1 0078/000 0", i, rv1, data1, fl1, cr1);
            end
        end
        drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
        pop(1);
        checks++; if (cr1 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL bp_no_accept got rdy=%b rv=%b exp 1 0", cr1, rv1); end
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        @(negedge clk);
        drive(1, 1'b1, 2'b10, 8'hFF, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if (cr1 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", cr1); end
        rst_n = 1'b0;
        #1;
        checks++; if (rv1 !== 1'b0 || data1 !== 16'h0 || fl1 !== 3'b0 || err1 !== 1'b0 || cr1 !== 1'b1) begin
            errors++; $display("FAIL rst_mid_outputs got rv=%b %h/%b err=%b rdy=%b exp 0 0000/000 0 1", rv1, data1, fl1, err1, cr1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 2'b00, 8'h01, 8'h01, lat);
        checks++; if (lat !== 1 || data1 !== 16'h0002 || fl1 !== 3'b000) begin
            errors++; $display("FAIL rst_mid_add got lat=%0d %h/%b exp 1 0002/000", lat, data1, fl1);
        end
        pop(1);
    endtask

    task automatic test_mul_disabled;
        int lat;
        issue(0, 2'b10, 8'h02, 8'h03, lat);
        checks++; if (lat !== 1)          begin errors++; $display("FAIL nomul_lat got %0d exp 1", lat); end
        checks++; if (err0 !== 1'b1)      begin errors++; $display("FAIL nomul_err got %b exp 1", err0); end
        checks++; if (data0 !== 16'h0000 || fl0 !== 3'b000) begin errors++; $display("FAIL nomul_data got %h/%b exp 0000/000", data0, fl0); end
        pop(0);
        issue(0, 2'b00, 8'h02, 8'h03, lat);
        checks++; if (err0 !== 1'b0 || data0 !== 16'h0005 || fl0 !== 3'b000) begin
            errors++; $display("FAIL nomul_next_add got err=%b %h/%b exp 0 0005/000", err0, data0, fl0);
        end
        pop(0);
    endtask

    initial begin
        rst_n = 1'b0;
        rr1 = 1'b0; rr0 = 1'b0;
        drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
        drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_add;
        test_sub_cmp;
        test_mul;
        test_backpressure;
        test_reset_mid_mul;
        test_mul_disabled;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
